aes_decrypt_core: RTL and testbench
===================================

# aes_decrypt_core

Iterative, handshaked AES inverse cipher. It accepts one 128-bit ciphertext block plus the raw cipher key, expands the key internally, and runs the inverse rounds one per clock. It returns the plaintext over a valid/ready interface. It is the receive-side counterpart of the encryption datapath and sits between the ciphertext source and the plaintext check/display logic. It is built from the existing `KeyExpansion`, `decryptRound`, `inv_shiftrow127`, `inverse_subByte` and `AddRoundKey` blocks.

## Interface
- `Nk`, default 6: key length in 32-bit words (4/6/8).
- `Nr`, default 12: number of rounds (10/12/14); must match `Nk` (`Nr` = `Nk`+6).
- `Nb`, default 4: state columns; fixed at 4.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ct_in`  in  128  ciphertext block; byte 0 is in bits [127:120].
- `key_in`  in  32*Nk  cipher key; word 0 is in the MSBs.
- `in_valid`  in  1  `ct_in`/`key_in` valid.
- `in_ready`  out  1  block can accept; a transfer occurs on an edge where `in_valid` && `in_ready`.
- `pt_out`  out  128  plaintext result.
- `out_valid`  out  1  `pt_out` valid.
- `out_ready`  in  1  consumer accepts; a transfer occurs on an edge where `out_valid` && `out_ready`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Registers:
  - `key_q` (32*Nk): captured key.
  - `state_q` (128): working state.
  - `rnd_q` (4 bits, enough for 0..14): current round index.
  - `fsm`: IDLE, INIT, ROUND, FINAL, DONE.
- Key schedule: `KeyExpansion` is combinational from `key_q`. Round key i is slice [127+128*(Nr-i) -: 128]. Round key 0 is the top 128 bits; round key Nr is [127:0].
- IDLE: `in_ready`=1. On an input transfer: `key_q`<=`key_in`, `state_q`<=`ct_in`, go to INIT.
- INIT (1 cycle): `state_q` <= `state_q` ^ rk[Nr]; `rnd_q` <= Nr-1; go to ROUND.
- ROUND: `state_q` <= `decryptRound`(`state_q`, rk[`rnd_q`]).
  - If `rnd_q`==1, go to FINAL.
  - Otherwise `rnd_q` <= `rnd_q`-1.
- FINAL (1 cycle): `pt_out` <= `inverse_subByte`(`inv_shiftrow127`(`state_q`)) ^ rk[0]; `out_valid` <= 1; go to DONE.
- DONE: hold `pt_out` and `out_valid`.
  - On an output transfer: `out_valid` <= 0, go to IDLE.
  - `out_ready` may be held low indefinitely; nothing changes while it is low.
- `in_ready` is high only in IDLE. There is no input buffering, and `in_valid` is ignored outside IDLE.
- `ct_in`/`key_in` are sampled only on the accept edge. They may change freely afterwards.
- `pt_out` keeps the last result after the handshake until the next FINAL overwrites it.
- Reset values (asynchronous, while `rst_n`=0):
  - `fsm`=IDLE, `state_q`=0, `key_q`=0, `rnd_q`=0.
  - `pt_out`=0, `out_valid`=0, `busy`=0.
  - `in_ready`=1; it is decoded from IDLE, but no transfer is taken while `rst_n`=0.
- Reset asserted mid-operation: abort immediately, drop `out_valid` asynchronously, discard the partial result. The first accept is possible on the first edge after release.
- Parameter check: `Nr`!=`Nk`+6 or `Nb`!=4 is a configuration error and shall trigger an elaboration-time `$error`.

## Timing
- Accept edge = E0.
- INIT executes at E1. ROUND occupies edges E2..E(Nr). FINAL executes at E(Nr+1).
- `out_valid` is first high after E(Nr+1): latency is Nr+1 cycles (13 for AES-192, 11 for AES-128, 15 for AES-256).
- Output handshake edge Eh returns the block to IDLE. `in_ready` is high from the cycle after Eh. Next accept is no earlier than Eh+1.
- Back-to-back throughput with `out_ready` tied high: one block per Nr+3 cycles.
- `busy` is high from the cycle after E0 through the cycle containing Eh.
- Critical path: the `KeyExpansion` chain plus one `decryptRound`. Single-cycle timing at the board clock is required. If it is not met, `key_q` is replaced by a registered expanded key, with no interface change.

## Test plan
- AES-192, default params: `key_in`=000102030405060708090a0b0c0d0e0f1011121314151617, `ct_in`=dda97ca4864cdfe06eaf70a0ec0d7191, `out_ready`=1 -> `pt_out`=00112233445566778899aabbccddeeff, `out_valid` first high exactly 13 cycles after accept, high for 1 cycle.
- AES-128 (`Nk`=4, `Nr`=10): key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> same plaintext after 11 cycles. AES-256 (`Nk`=8, `Nr`=14): key 00..1f, ct 8ea2b7ca516745bfeafc49904b496089 -> same plaintext after 15 cycles.
- Backpressure: `out_ready`=0 for 20 cycles after `out_valid` -> `pt_out`/`out_valid` stable, `in_ready`=0, and a second `in_valid` is not accepted. Raising `out_ready` completes the handshake; `in_ready`=1 on the next cycle.
- Input corruption: change `ct_in`/`key_in` to random values on the cycle after accept -> result is still the FIPS plaintext.
- Reset mid-run: assert `rst_n`=0 at round 5 -> `out_valid`=0, `busy`=0, `pt_out`=0 immediately. After release, a fresh vector decrypts correctly with the nominal latency.
- Back-to-back: two vectors with `out_ready`=1 and `in_valid` held high -> both plaintexts correct, accept edges spaced exactly Nr+3 cycles apart.

Source files
------------

// File: rtl/aes_decrypt_core.sv
// rtl/aes_decrypt_core.sv - iterative handshaked AES inverse cipher with combinational key schedule
package aes_gf_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 = a^2 * a^4 * ... * a^128 is the field inverse, and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

module inverse_subByte (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  always_comb begin
    dout = '0;
    for (int k = 0; k < 16; k++) dout[8*k +: 8] = aes_gf_pkg::inv_sbox(din[8*k +: 8]);
  end
endmodule

module inv_shiftrow127 (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  // byte 4*c+r sits at row r, column c; row r rotates right by r columns
  always_comb begin
    dout = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        dout[127 - 8*(4*c + r) -: 8] = din[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
  end
endmodule

module AddRoundKey (
  input  logic [127:0] din,
  input  logic [127:0] round_key,
  output logic [127:0] dout
);
  assign dout = din ^ round_key;
endmodule

module decryptRound (
  input  logic [127:0] din,
  input  logic [127:0] round_key,
  output logic [127:0] dout
);
  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {
      aes_gf_pkg::gf_mul(a0, 8'h0e) ^ aes_gf_pkg::gf_mul(a1, 8'h0b) ^
      aes_gf_pkg::gf_mul(a2, 8'h0d) ^ aes_gf_pkg::gf_mul(a3, 8'h09),
      aes_gf_pkg::gf_mul(a0, 8'h09) ^ aes_gf_pkg::gf_mul(a1, 8'h0e) ^
      aes_gf_pkg::gf_mul(a2, 8'h0b) ^ aes_gf_pkg::gf_mul(a3, 8'h0d),
      aes_gf_pkg::gf_mul(a0, 8'h0d) ^ aes_gf_pkg::gf_mul(a1, 8'h09) ^
      aes_gf_pkg::gf_mul(a2, 8'h0e) ^ aes_gf_pkg::gf_mul(a3, 8'h0b),
      aes_gf_pkg::gf_mul(a0, 8'h0b) ^ aes_gf_pkg::gf_mul(a1, 8'h0d) ^
      aes_gf_pkg::gf_mul(a2, 8'h09) ^ aes_gf_pkg::gf_mul(a3, 8'h0e)
    };
  endfunction

  inv_shiftrow127 u_shift (.din(din), .dout(shifted));
  inverse_subByte u_sub (.din(shifted), .dout(subbed));
  AddRoundKey u_ark (.din(subbed), .round_key(round_key), .dout(keyed));

  always_comb begin
    dout = '0;
    for (int c = 0; c < 4; c++) dout[127 - 32*c -: 32] = inv_mix_col(keyed[127 - 32*c -: 32]);
  end
endmodule

module KeyExpansion #(
  parameter int Nk = 6,
  parameter int Nr = 12
) (
  input  logic [32*Nk-1:0]      key,
  output logic [128*(Nr+1)-1:0] w
);
  localparam int NW = 4 * (Nr + 1);

  logic [31:0] words [NW];

  // word 0 lands in the MSBs so round key i is w[127+128*(Nr-i) -: 128]
  always_comb begin
    logic [31:0] t;
    logic [7:0]  rc;
    words = '{default: '0};
    w = '0;
    t = '0;
    rc = 8'h01;
    for (int i = 0; i < NW; i++) begin
      if (i < Nk) begin
        words[i] = key[32*Nk-1-32*i -: 32];
      end else begin
        t = words[i-1];
        if (i % Nk == 0) begin
          t = aes_gf_pkg::sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = aes_gf_pkg::xtime(rc);
        end else if (Nk > 6 && i % Nk == 4) begin
          t = aes_gf_pkg::sub_word(t);
        end
        words[i] = words[i-Nk] ^ t;
      end
      w[128*(Nr+1)-1-32*i -: 32] = words[i];
    end
  end
endmodule

module aes_decrypt_core #(
  parameter int Nk = 6,
  parameter int Nr = 12,
  parameter int Nb = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [127:0]      ct_in,
  input  logic [32*Nk-1:0]  key_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [127:0]      pt_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  if (Nr != Nk + 6 || Nb != 4) begin : g_cfg_error
    $error("aes_decrypt_core: unsupported configuration Nk=%0d Nr=%0d Nb=%0d", Nk, Nr, Nb);
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] RND_START = 4'(Nr - 1);

  logic [2:0]              fsm;
  logic [32*Nk-1:0]        key_q;
  logic [127:0]            state_q;
  logic [3:0]              rnd_q;
  logic [128*(Nr+1)-1:0]   sched;
  logic [127:0]            rk [Nr+1];
  logic [127:0]            cur_rk;
  logic [127:0]            round_out;
  logic [127:0]            final_shift;
  logic [127:0]            final_sub;
  logic [127:0]            final_out;

  KeyExpansion #(.Nk(Nk), .Nr(Nr)) u_keyexp (.key(key_q), .w(sched));

  always_comb begin
    for (int i = 0; i <= Nr; i++) rk[i] = sched[127 + 128*(Nr - i) -: 128];
    cur_rk = rk[rnd_q];
  end

  decryptRound u_round (.din(state_q), .round_key(cur_rk), .dout(round_out));

  // last round has no InvMixColumns
  inv_shiftrow127 u_fshift (.din(state_q), .dout(final_shift));
  inverse_subByte u_fsub (.din(final_shift), .dout(final_sub));
  AddRoundKey u_fark (.din(final_sub), .round_key(rk[0]), .dout(final_out));

  assign in_ready = (fsm == S_IDLE);
  assign busy     = (fsm != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= S_IDLE;
      key_q     <= '0;
      state_q   <= '0;
      rnd_q     <= '0;
      pt_out    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (in_valid) begin
            key_q   <= key_in;
            state_q <= ct_in;
            fsm     <= S_INIT;
          end
        end
        S_INIT: begin
          state_q <= state_q ^ rk[Nr];
          rnd_q   <= RND_START;
          fsm     <= S_ROUND;
        end
        S_ROUND: begin
          state_q <= round_out;
          if (rnd_q == 4'd1) fsm <= S_FINAL;
          else rnd_q <= rnd_q - 4'd1;
        end
        S_FINAL: begin
          pt_out    <= final_out;
          out_valid <= 1'b1;
          fsm       <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm       <= S_IDLE;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decrypt_core.sv
// tb/tb_aes_decrypt_core.sv - scoreboard bench for aes_decrypt_core against a forward-cipher model
module tb_aes_decrypt_core;
  localparam int NK = 6;
  localparam int NR = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [127:0]      ct_in = '0;
  logic [32*NK-1:0]  key_in = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [127:0]      pt_out;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              busy;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [127:0] exp_q[$];
  int acc_q[$];
  logic ov_d = 1'b0;
  logic [7:0] sb [256];

  aes_decrypt_core #(.Nk(NK), .Nr(NR), .Nb(4)) dut (
    .clk(clk), .rst_n(rst_n), .ct_in(ct_in), .key_in(key_in), .in_valid(in_valid),
    .in_ready(in_ready), .pt_out(pt_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  // forward cipher: the DUT must invert this
  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [32*NK-1:0] key);
    logic [31:0] w [4*(NR+1)];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [31:0] tmp;
    logic [7:0] rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4*(NR+1); i++) begin
      if (i < NK) w[i] = key[32*NK-1-32*i -: 32];
      else begin
        tmp = w[i-1];
        if (i % NK == 0) begin
          tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (NK > 6 && i % NK == 4) tmp = subw(tmp);
        w[i] = w[i-NK] ^ tmp;
      end
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int rnd = 1; rnd <= NR; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = sb[s[4*((c+r)%4)+r]];
      for (int c = 0; c < 4; c++) begin
        if (rnd < NR) begin
          s[4*c+0] = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
      end
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [32*NK-1:0] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input logic [127:0] ct, input logic [32*NK-1:0] key, input logic [127:0] expv, input bit hold);
    int n;
    in_valid = 1'b1; ct_in = ct; key_in = key;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 8*NR);
    if (!in_ready) begin
      check(1'b0, "accept_timeout", 128'(in_ready), 128'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    exp_q.push_back(expv);
    acc_q.push_back(cyc);
    last_acc = cyc;
    if (!hold) begin
      in_valid = 1'b0;
      ct_in = rnd128();
      key_in = rnd_key();
    end
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid && n < 4*NR) begin @(negedge clk); n++; end
    check(out_valid == 1'b1, "out_valid_timeout", 128'(out_valid), 128'd1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      ov_d <= 1'b0;
    end else begin
      if (out_valid && !ov_d) begin
        if (acc_q.size() == 0) check(1'b0, "spurious_out_valid", 128'd1, 128'd0);
        else begin
          int a;
          a = acc_q.pop_front();
          check(cyc - a == NR + 1, "latency", 128'(cyc - a), 128'(NR + 1));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check(1'b0, "unexpected_output", pt_out, 128'd0);
        else begin
          logic [127:0] e;
          e = exp_q.pop_front();
          check(pt_out == e, "plaintext", pt_out, e);
        end
      end
      ov_d <= out_valid;
    end
  end

  initial begin
    logic [127:0] pt, bp_exp;
    logic [32*NK-1:0] key;
    int t_rel, t_a, n;
    build_sbox();

    in_valid = 1'b1; ct_in = rnd128(); key_in = rnd_key();
    repeat (3) begin
      @(negedge clk);
      check(in_ready == 1'b1, "rst_in_ready", 128'(in_ready), 128'd1);
      check(busy == 1'b0, "rst_busy", 128'(busy), 128'd0);
      check(out_valid == 1'b0, "rst_out_valid", 128'(out_valid), 128'd0);
      check(pt_out == 128'd0, "rst_pt_out", pt_out, 128'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check(busy == 1'b0, "no_accept_in_reset", 128'(busy), 128'd0);
    @(posedge clk); #1;

    key = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    pt = 128'h00112233445566778899aabbccddeeff;
    check(encrypt(pt, key) == 128'hdda97ca4864cdfe06eaf70a0ec0d7191, "model_fips", encrypt(pt, key),
          128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    send(128'hdda97ca4864cdfe06eaf70a0ec0d7191, key, pt, 1'b0);
    wait_out_valid();
    @(negedge clk);
    check(out_valid == 1'b0, "valid_one_cycle", 128'(out_valid), 128'd0);
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      pt = rnd128(); key = rnd_key();
      send(encrypt(pt, key), key, pt, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        out_ready = 1'b0;
        repeat (NR + 2 + $urandom_range(0, 5)) @(posedge clk);
        #1; out_ready = 1'b1;
      end
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
    end

    out_ready = 1'b0;
    pt = rnd128(); key = rnd_key(); bp_exp = pt;
    send(encrypt(pt, key), key, pt, 1'b0);
    wait_out_valid();
    in_valid = 1'b1; ct_in = rnd128(); key_in = rnd_key();
    repeat (20) begin
      @(negedge clk);
      check(out_valid == 1'b1, "bp_out_valid", 128'(out_valid), 128'd1);
      check(pt_out == bp_exp, "bp_pt_stable", pt_out, bp_exp);
      check(in_ready == 1'b0, "bp_in_ready", 128'(in_ready), 128'd0);
      check(busy == 1'b1, "bp_busy", 128'(busy), 128'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check(in_ready == 1'b1, "bp_in_ready_after", 128'(in_ready), 128'd1);
    check(busy == 1'b0, "bp_busy_after", 128'(busy), 128'd0);
    check(out_valid == 1'b0, "bp_valid_after", 128'(out_valid), 128'd0);
    @(posedge clk); #1;

    pt = rnd128(); key = rnd_key();
    send(encrypt(pt, key), key, pt, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check(busy == 1'b1, "busy_mid_run", 128'(busy), 128'd1);
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check(out_valid == 1'b0, "midrst_out_valid", 128'(out_valid), 128'd0);
    check(busy == 1'b0, "midrst_busy", 128'(busy), 128'd0);
    check(pt_out == 128'd0, "midrst_pt_out", pt_out, 128'd0);
    check(in_ready == 1'b1, "midrst_in_ready", 128'(in_ready), 128'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    t_rel = cyc;
    pt = rnd128(); key = rnd_key();
    send(encrypt(pt, key), key, pt, 1'b0);
    check(last_acc == t_rel + 1, "accept_after_release", 128'(last_acc - t_rel), 128'd1);

    out_ready = 1'b1;
    pt = rnd128(); key = rnd_key();
    send(encrypt(pt, key), key, pt, 1'b1);
    t_a = last_acc;
    pt = rnd128(); key = rnd_key();
    send(encrypt(pt, key), key, pt, 1'b0);
    check(last_acc - t_a == NR + 3, "b2b_spacing", 128'(last_acc - t_a), 128'(NR + 3));

    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 8*NR) begin @(negedge clk); n++; end
    check(exp_q.size() == 0, "drain", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
